// File: rtl/wht_2d_pkg.sv
// Shared definitions for the streaming 4x4 Walsh-Hadamard transform.
// The Hadamard sign table and lane indexing are used by the top and by the butterfly.
package wht_2d_pkg;

  localparam int LANES = 4;

  // H4_NEG[i][k] is set where H4 row i, column k is -1 (natural Hadamard order).
  localparam logic [3:0][3:0] H4_NEG = {4'b0110, 4'b1100, 4'b1010, 4'b0000};

  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

  function automatic int lane_hi(input int k, input int w);
    return (k + 1) * w - 1;
  endfunction

endpackage

// File: rtl/wht_2d_wht4.sv
// Combinational 4-point Walsh-Hadamard butterfly.
// Each lane is sign-extended from IW to OW bits before the adds; results wrap at OW bits.
module wht4
  import wht_2d_pkg::*;
#(
  parameter int IW = 9,
  parameter int OW = 11
) (
  input  logic [LANES*IW-1:0] x_i,
  output logic [LANES*OW-1:0] y_o
);

  logic signed [OW-1:0] ext_s [LANES];
  logic signed [OW-1:0] acc_s;

  for (genvar k = 0; k < LANES; k++) begin : g_ext
    assign ext_s[k] = {{(OW-IW){x_i[lane_hi(k, IW)]}}, x_i[lane_hi(k, IW):lane_lo(k, IW)]};
  end

  // Signed sum of the four lanes under each H4 row.
  always_comb begin
    y_o   = '0;
    acc_s = '0;
    for (int i = 0; i < LANES; i++) begin
      acc_s = '0;
      for (int k = 0; k < LANES; k++) begin
        acc_s = H4_NEG[i][k] ? (acc_s - ext_s[k]) : (acc_s + ext_s[k]);
      end
      y_o[lane_lo(i, OW) +: OW] = acc_s;
    end
  end

endmodule

// File: rtl/wht_2d.sv
// Streaming 4x4 2-D Walsh-Hadamard transform Y = H*X*H, one row in and one row out per beat.
// Rows go through a row butterfly into Z; a completed Z is column-transformed into an output bank.
module wht_2d
  import wht_2d_pkg::*;
#(
  parameter int WIDTH0 = 9,
  parameter int WIDTH1 = 11,
  parameter int WIDTH2 = 13
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*WIDTH0-1:0] blk_i,
  input  logic                    blk_valid,
  output logic [WIDTH2-1:0]       pix_out0,
  output logic [WIDTH2-1:0]       pix_out1,
  output logic [WIDTH2-1:0]       pix_out2,
  output logic [WIDTH2-1:0]       pix_out3,
  output logic                    pix_ovalid
);

  logic [LANES*WIDTH1-1:0] z_row_s;
  logic [LANES*WIDTH1-1:0] z_q      [LANES];
  logic [LANES*WIDTH1-1:0] col_in_s [LANES];
  logic [LANES*WIDTH2-1:0] col_out_s[LANES];
  logic [LANES*WIDTH2-1:0] y_row_s  [LANES];
  logic [LANES*WIDTH2-1:0] bank_q   [LANES];

  logic [1:0]              rcnt_q, rcnt_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic [1:0]              rd_ptr_q, rd_ptr_d;
  logic [LANES*WIDTH2-1:0] pix_q, pix_d;
  logic                    ovalid_q, ovalid_d;

  wht4 #(.IW(WIDTH0), .OW(WIDTH1)) u_row (
    .x_i (blk_i),
    .y_o (z_row_s)
  );

  // Column j of Z feeds butterfly j; its output lane i is Y[i][j], regrouped into row i.
  for (genvar j = 0; j < LANES; j++) begin : g_col
    for (genvar k = 0; k < LANES; k++) begin : g_pack
      assign col_in_s[j][lane_lo(k, WIDTH1) +: WIDTH1] = z_q[k][lane_lo(j, WIDTH1) +: WIDTH1];
      assign y_row_s[k][lane_lo(j, WIDTH2) +: WIDTH2]  = col_out_s[j][lane_lo(k, WIDTH2) +: WIDTH2];
    end
    wht4 #(.IW(WIDTH1), .OW(WIDTH2)) u_col (
      .x_i (col_in_s[j]),
      .y_o (col_out_s[j])
    );
  end

  // Next-state for row counter, block flag and readout sequencing.
  always_comb begin
    rcnt_d   = rcnt_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    rd_ptr_d = rd_ptr_q;
    pix_d    = pix_q;
    ovalid_d = 1'b0;
    if (blk_valid) begin
      rcnt_d = rcnt_q + 2'd1;
      done_d = (rcnt_q == 2'd3);
    end else begin
      rcnt_d = rcnt_q;
    end
    // Row 0 leaves straight from the column stage; rows 1..3 come from the bank.
    if (done_q) begin
      pix_d    = y_row_s[0];
      ovalid_d = 1'b1;
      rd_ptr_d = 2'd1;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      pix_d    = bank_q[rd_ptr_q];
      ovalid_d = 1'b1;
      rd_ptr_d = rd_ptr_q + 2'd1;
      busy_d   = (rd_ptr_q != 2'd3);
    end else begin
      pix_d    = pix_q;
      ovalid_d = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q   <= 2'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      rd_ptr_q <= 2'd0;
      pix_q    <= '0;
      ovalid_q <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      rd_ptr_q <= rd_ptr_d;
      pix_q    <= pix_d;
      ovalid_q <= ovalid_d;
    end
  end

  // Z row buffer and output bank; the bank load frees Z for the next block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < LANES; r++) begin
        z_q[r]    <= '0;
        bank_q[r] <= '0;
      end
    end else begin
      if (blk_valid) begin
        z_q[rcnt_q] <= z_row_s;
      end else begin
        z_q[rcnt_q] <= z_q[rcnt_q];
      end
      if (done_q) begin
        for (int r = 0; r < LANES; r++) begin
          bank_q[r] <= y_row_s[r];
        end
      end else begin
        for (int r = 0; r < LANES; r++) begin
          bank_q[r] <= bank_q[r];
        end
      end
    end
  end

  assign pix_out0   = pix_q[lane_lo(0, WIDTH2) +: WIDTH2];
  assign pix_out1   = pix_q[lane_lo(1, WIDTH2) +: WIDTH2];
  assign pix_out2   = pix_q[lane_lo(2, WIDTH2) +: WIDTH2];
  assign pix_out3   = pix_q[lane_lo(3, WIDTH2) +: WIDTH2];
  assign pix_ovalid = ovalid_q;

endmodule

// File: tb/tb_wht_2d.sv
// Bench for wht_2d: forward instance chained into a wider inverse instance.
// A matrix model fills scoreboards; the inverse output must equal 16*X.
module tb_wht_2d;

  localparam int W0 = 9,  W1 = 11, W2 = 13;
  localparam int V0 = 13, V1 = 15, V2 = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4*W0-1:0] blk_i = '0;
  logic          blk_valid = 1'b0;
  logic [W2-1:0] p0, p1, p2, p3;
  logic          pv;
  logic [V2-1:0] r0, r1, r2, r3;
  logic          rv;

  wht_2d #(.WIDTH0(W0), .WIDTH1(W1), .WIDTH2(W2)) dut (
    .clk(clk), .rst_n(rst_n), .blk_i(blk_i), .blk_valid(blk_valid),
    .pix_out0(p0), .pix_out1(p1), .pix_out2(p2), .pix_out3(p3), .pix_ovalid(pv)
  );

  wht_2d #(.WIDTH0(V0), .WIDTH1(V1), .WIDTH2(V2)) inv (
    .clk(clk), .rst_n(rst_n), .blk_i({p3, p2, p1, p0}), .blk_valid(pv),
    .pix_out0(r0), .pix_out1(r1), .pix_out2(r2), .pix_out3(r3), .pix_ovalid(rv)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] q1[$];
  logic [127:0] q2[$];
  logic [127:0] e1m, e2m;
  int xb[4][4];
  int row_n = 0;
  int ov1_cnt = 0;
  int pos1 = 0, pos2 = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int hs(input int i, input int k);
    return ($countones(i & k) % 2 == 1) ? -1 : 1;
  endfunction

  function automatic logic [127:0] pk13(input int a, input int b, input int c, input int d);
    logic [127:0] r;
    r = '0;
    r[0*W2 +: W2] = W2'(a);
    r[1*W2 +: W2] = W2'(b);
    r[2*W2 +: W2] = W2'(c);
    r[3*W2 +: W2] = W2'(d);
    return r;
  endfunction

  task automatic push_block();
    logic [127:0] e1, e2;
    int y;
    for (int i = 0; i < 4; i++) begin
      e1 = '0;
      e2 = '0;
      for (int j = 0; j < 4; j++) begin
        y = 0;
        for (int k = 0; k < 4; k++)
          for (int l = 0; l < 4; l++)
            y += hs(i, k) * xb[k][l] * hs(l, j);
        e1[j*W2 +: W2] = W2'(y);
        e2[j*V2 +: V2] = V2'(16 * xb[i][j]);
      end
      q1.push_back(e1);
      q2.push_back(e2);
    end
  endtask

  task automatic send_row(input int a, input int b, input int c, input int d);
    @(negedge clk);
    blk_i = {W0'(d), W0'(c), W0'(b), W0'(a)};
    blk_valid = 1'b1;
    xb[row_n][0] = a; xb[row_n][1] = b; xb[row_n][2] = c; xb[row_n][3] = d;
    if (row_n == 3) push_block();
    row_n = (row_n + 1) % 4;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      blk_valid = 1'b0;
    end
  endtask

  task automatic send_rand_row();
    send_row(int'($urandom_range(511)) - 256, int'($urandom_range(511)) - 256,
             int'($urandom_range(511)) - 256, int'($urandom_range(511)) - 256);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q1.size() != 0 || q2.size() != 0) && t < 200) begin
      idle(1);
      t++;
    end
    check_eq("drain_q1", q1.size(), 0);
    check_eq("drain_q2", q2.size(), 0);
  endtask

  // Scoreboard and per-block contiguity on both instances.
  always @(negedge clk) begin
    if (!rst_n) begin
      pos1 = 0;
      pos2 = 0;
    end else begin
      if (pos1 != 0) check_eq("contig1", pv, 1'b1);
      if (pv) begin
        ov1_cnt++;
        check_eq("q1_has", q1.size() > 0, 1'b1);
        if (q1.size() > 0) begin
          e1m = q1.pop_front();
          check_eq("y_row", {p3, p2, p1, p0}, e1m);
        end
        pos1 = (pos1 + 1) % 4;
      end
      if (pos2 != 0) check_eq("contig2", rv, 1'b1);
      if (rv) begin
        check_eq("q2_has", q2.size() > 0, 1'b1);
        if (q2.size() > 0) begin
          e2m = q2.pop_front();
          check_eq("x16_row", {r3, r2, r1, r0}, e2m);
        end
        pos2 = (pos2 + 1) % 4;
      end
    end
  end

  initial begin
    int snap, t;
    repeat (3) @(negedge clk);
    check_eq("rst_out1", {pv, p3, p2, p1, p0}, '0);
    check_eq("rst_out2", {rv, r3, r2, r1, r0}, '0);
    rst_n = 1'b1;
    idle(3);
    check_eq("idle_out1", {pv, p3, p2, p1, p0}, '0);

    // DC block with explicit valid timing.
    for (int r = 0; r < 4; r++) send_row(1, 1, 1, 1);
    for (int c = 0; c < 6; c++) begin
      idle(1);
      check_eq($sformatf("dc_ov%0d", c), pv, (c >= 1 && c <= 4));
    end
    drain();

    send_row(0, 1, 0, 0);
    for (int r = 0; r < 3; r++) send_row(0, 0, 0, 0);
    idle(6);
    send_row(1, 0, 0, 0);
    for (int r = 0; r < 3; r++) send_row(0, 0, 0, 0);
    drain();

    // Mixed block with a literal row-0 expectation and bounded wait.
    for (int r = 0; r < 3; r++) send_row(128, 128, 0, 1);
    send_row(128, 128, 1, 2);
    t = 0;
    idle(1);
    while (!pv && t < 10) begin
      idle(1);
      t++;
    end
    check_eq("mixed_wait", pv, 1'b1);
    check_eq("mixed_r0", {p3, p2, p1, p0}, pk13(1030, -4, 1018, 4));
    drain();

    for (int r = 0; r < 4; r++) send_row(-256, -256, -256, -256);
    drain();

    // Back-to-back random blocks, one gap inside the second block.
    for (int b = 0; b < 4; b++) begin
      for (int r = 0; r < 4; r++) begin
        send_rand_row();
        if (b == 1 && r == 1) idle(1);
      end
    end
    drain();

    // Reset after two rows: no output, then a clean block.
    send_row(5, 6, 7, 8);
    send_row(9, 10, 11, 12);
    @(negedge clk);
    blk_valid = 1'b0;
    rst_n = 1'b0;
    row_n = 0;
    snap = ov1_cnt;
    idle(2);
    rst_n = 1'b1;
    idle(8);
    check_eq("rst_mid_noout", ov1_cnt, snap);
    for (int r = 0; r < 4; r++) send_rand_row();
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
